// File: rtl/io_in_ports_pkg.sv
// rtl/io_in_ports_pkg.sv - shared input/output port bank definitions (package io_defs)
package io_defs;

    localparam int NUM_IN_PORTS  = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DB_CYCLES = 4;

    typedef logic [1:0] port_addr_t;

    function automatic logic [NUM_IN_PORTS-1:0] port_onehot(input port_addr_t addr);
        logic [NUM_IN_PORTS-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/io_in_ports_sync.sv
// rtl/io_in_ports_sync.sv - per-port synchroniser and capture register (module io_in_sync)
// Optional debounce filter built when IN_DEBOUNCE_EN is defined.
module io_in_sync
    import io_defs::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] cap,
    output logic             changed
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             changed_c;

    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
    end

`ifdef IN_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DB_CYCLES);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_nxt;

    // The counter tracks how many consecutive cycles sync2 has held the candidate.
    always_comb begin
        cand_d  = cand_q;
        cnt_nxt = '0;
        if (sync2_q == cap_q) begin
            cnt_nxt = '0;
        end else if (sync2_q != cand_q) begin
            cand_d  = sync2_q;
            cnt_nxt = CW'(1);
        end else begin
            cnt_nxt = cnt_q + 1'b1;
        end
        // sync2 equals the (possibly just-loaded) candidate whenever capture fires
        changed_c = (sync2_q != cap_q) && (cnt_nxt == CNT_DONE);
        cap_d     = changed_c ? sync2_q : cap_q;
        cnt_d     = changed_c ? '0 : cnt_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    localparam int db_cycles_unused = DB_CYCLES;

    always_comb begin
        changed_c = (sync2_q != cap_q);
        cap_d     = changed_c ? sync2_q : cap_q;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cap_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cap_q   <= cap_d;
        end
    end

    assign cap     = cap_q;
    assign changed = changed_c;

endmodule

// File: rtl/io_in_ports.sv
// rtl/io_in_ports.sv - four synchronised input ports with sticky new-data flags and irq
// Debounce per port is enabled with IN_DEBOUNCE_EN.
module io_in_ports
    import io_defs::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        port_in0,
    input  logic [WIDTH-1:0]        port_in1,
    input  logic [WIDTH-1:0]        port_in2,
    input  logic [WIDTH-1:0]        port_in3,
    input  logic                    rd_en,
    input  logic [1:0]              rd_port,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_new,
    output logic [NUM_IN_PORTS-1:0] new_flags,
    output logic                    irq
);

    logic [WIDTH-1:0]        pins [NUM_IN_PORTS];
    logic [WIDTH-1:0]        caps [NUM_IN_PORTS];
    logic [NUM_IN_PORTS-1:0] changed;

    logic [NUM_IN_PORTS-1:0] flags_q, flags_d;
    logic [NUM_IN_PORTS-1:0] clr;
    logic [WIDTH-1:0]        rd_data_q, rd_data_d;
    logic                    rd_new_q, rd_new_d;
    logic                    irq_q, irq_d;

    assign pins[0] = port_in0;
    assign pins[1] = port_in1;
    assign pins[2] = port_in2;
    assign pins[3] = port_in3;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_port
        io_in_sync #(
            .WIDTH     (WIDTH),
            .DB_CYCLES (DB_CYCLES)
        ) u_sync (
            .clk     (clk),
            .reset   (reset),
            .pin_in  (pins[i]),
            .cap     (caps[i]),
            .changed (changed[i])
        );
    end

    // A capture on the same edge as a read of that port keeps the flag set.
    always_comb begin
        clr       = rd_en ? port_onehot(rd_port) : '0;
        flags_d   = (flags_q & ~clr) | changed;
        irq_d     = |flags_d;
        rd_data_d = rd_en ? caps[rd_port]    : rd_data_q;
        rd_new_d  = rd_en ? flags_q[rd_port] : rd_new_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= '0;
            rd_data_q <= '0;
            rd_new_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            rd_data_q <= rd_data_d;
            rd_new_q  <= rd_new_d;
            irq_q     <= irq_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_new    = rd_new_q;
    assign new_flags = flags_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_io_in_ports.sv
// tb/tb_io_in_ports.sv - self-checking bench for io_in_ports (directed table plus random vs model)
module tb_io_in_ports;

    localparam int DB = 4;
`ifdef IN_DEBOUNCE_EN
    localparam int MDB = DB;
`else
    localparam int MDB = 1;
`endif
    localparam int LAT = 2 + MDB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pin [4];
    logic       rd_en = 1'b0;
    logic [1:0] rd_port = 2'd0;
    logic [7:0] rd_data;
    logic       rd_new;
    logic [3:0] new_flags;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_en = 1'b0;

    io_in_ports #(.WIDTH(8), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .port_in0  (pin[0]),
        .port_in1  (pin[1]),
        .port_in2  (pin[2]),
        .port_in3  (pin[3]),
        .rd_en     (rd_en),
        .rd_port   (rd_port),
        .rd_data   (rd_data),
        .rd_new    (rd_new),
        .new_flags (new_flags),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a port takes a new value once the synchronised pin has shown that
    // same value (different from the held copy) for MDB consecutive cycles.
    logic [7:0] m_s1 [4];
    logic [7:0] m_s2 [4];
    logic [7:0] m_cap [4];
    logic [7:0] m_win [4][$];
    logic [3:0] m_flag;
    logic [7:0] m_rd;
    logic       m_rdnew;

    always @(posedge clk or posedge reset) begin : model
        logic [3:0] mset, mclr;
        bit stable;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = '0; m_s2[i] = '0; m_cap[i] = '0;
                m_win[i].delete();
                for (int k = 0; k < MDB; k++) m_win[i].push_back(8'h00);
            end
            m_flag = '0; m_rd = '0; m_rdnew = 1'b0;
        end else begin
            mset = '0; mclr = '0;
            for (int i = 0; i < 4; i++) begin
                m_win[i].push_back(m_s2[i]);
                if (m_win[i].size() > MDB) void'(m_win[i].pop_front());
                stable = 1'b1;
                foreach (m_win[i][k]) if (m_win[i][k] != m_s2[i]) stable = 1'b0;
                if (stable && m_s2[i] != m_cap[i]) mset[i] = 1'b1;
            end
            if (rd_en) begin
                m_rd = m_cap[rd_port]; m_rdnew = m_flag[rd_port]; mclr[rd_port] = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (mset[i]) m_cap[i] = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = pin[i];
            end
            m_flag = (m_flag & ~mclr) | mset;
        end
    end

    typedef struct {
        bit         chg;
        int         cp;
        logic [7:0] cv;
        int         wt;
        logic [1:0] rp;
        logic [7:0] ed;
        logic       en;
        logic [3:0] ef;
    } vec_t;

    vec_t vecs [6];

    task automatic do_read(input logic [1:0] p);
        rd_en = 1'b1; rd_port = p;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int hold [4];
        vecs[0] = '{1'b0, 0, 8'h00, 0,       2'd1, 8'h00, 1'b0, 4'b0000};
        vecs[1] = '{1'b1, 1, 8'h5A, LAT,     2'd1, 8'h5A, 1'b1, 4'b0000};
        vecs[2] = '{1'b1, 3, 8'h11, LAT,     2'd0, 8'hA5, 1'b0, 4'b1000};
        vecs[3] = '{1'b0, 0, 8'h00, 0,       2'd3, 8'h11, 1'b1, 4'b0000};
        vecs[4] = '{1'b1, 0, 8'h0F, LAT,     2'd0, 8'h0F, 1'b1, 4'b0000};
        vecs[5] = '{1'b1, 2, 8'hC3, LAT - 1, 2'd2, 8'h3C, 1'b0, 4'b0100};

        for (int i = 0; i < 4; i++) pin[i] = 8'h00;
        pin[0] = 8'hA5;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_rd_new", rd_new, 1'b0);
        chk("reset_flags", new_flags, 4'h0);
        chk("reset_irq", irq, 1'b0);

        reset = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            @(negedge clk);
            chk("post_reset_flags", new_flags, (e == LAT) ? 4'b0001 : 4'b0000);
            chk("post_reset_irq", irq, (e == LAT) ? 1'b1 : 1'b0);
        end
        do_read(2'd0);
        chk("cap0_data", rd_data, 8'hA5);
        chk("cap0_new", rd_new, 1'b1);
        chk("cap0_flags", new_flags, 4'h0);

        pin[2] = 8'h3C;
        repeat (LAT) @(negedge clk);
        chk("p2_flag_set", new_flags, 4'b0100);
        do_read(2'd2);
        chk("p2_data", rd_data, 8'h3C);
        chk("p2_new", rd_new, 1'b1);
        chk("p2_flags", new_flags, 4'h0);
        chk("p2_irq", irq, 1'b0);

        foreach (vecs[v]) begin
            if (vecs[v].chg) pin[vecs[v].cp] = vecs[v].cv;
            repeat (vecs[v].wt) @(negedge clk);
            do_read(vecs[v].rp);
            chk($sformatf("vec%0d_data", v), rd_data, vecs[v].ed);
            chk($sformatf("vec%0d_new", v), rd_new, vecs[v].en);
            chk($sformatf("vec%0d_flags", v), new_flags, vecs[v].ef);
        end

        pin[3] = 8'h81;
        repeat (LAT - 1) @(negedge clk);
        do_read(2'd3);
        chk("clr_set_flags", new_flags, 4'b1100);
        chk("clr_set_old_data", rd_data, 8'h11);
        do_read(2'd3);
        chk("clr_set_data2", rd_data, 8'h81);
        chk("clr_set_new2", rd_new, 1'b1);
        do_read(2'd2);
        chk("p2_reread", rd_data, 8'hC3);
        chk("flags_clear", new_flags, 4'h0);

`ifdef IN_DEBOUNCE_EN
        pin[0] = 8'h00;
        repeat (LAT) @(negedge clk);
        do_read(2'd0);
        pin[0] = 8'hFF;
        repeat (3) @(negedge clk);
        pin[0] = 8'h00;
        repeat (10) @(negedge clk);
        chk("glitch_no_flag", new_flags, 4'h0);
        do_read(2'd0);
        chk("glitch_cap0", rd_data, 8'h00);
        pin[0] = 8'hFF;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            chk("db_hold_flag", new_flags[0], (e == 6) ? 1'b1 : 1'b0);
        end
        do_read(2'd0);
        chk("db_hold_data", rd_data, 8'hFF);
`endif

        pin[1] = 8'h77;
        repeat ((MDB > 1) ? 4 : 2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_rd_data", rd_data, 8'h00);
        chk("mid_reset_rd_new", rd_new, 1'b0);
        chk("mid_reset_flags", new_flags, 4'h0);
        chk("mid_reset_irq", irq, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            @(negedge clk);
            chk("recapture_flags", new_flags, (e == LAT) ? 4'b1111 : 4'b0000);
        end
        do_read(2'd1);
        chk("recapture_p1", rd_data, 8'h77);
        chk("recapture_p1_new", rd_new, 1'b1);

        model_en = 1'b1;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            chk("rnd_rd_data", rd_data, m_rd);
            chk("rnd_rd_new", rd_new, m_rdnew);
            chk("rnd_flags", new_flags, m_flag);
            chk("rnd_irq", irq, |m_flag);
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    pin[i]  = ($urandom_range(0, 1) == 0) ? pin[i] ^ 8'h01 : 8'($urandom);
                    hold[i] = $urandom_range(1, 2 * MDB + 3);
                end else begin
                    hold[i]--;
                end
            end
            rd_en   = ($urandom_range(0, 2) == 0);
            rd_port = 2'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
